// File: rtl/sdf_pkg.sv
// Shared SDF pipeline definitions: default sizes and index helpers.
package sdf_pkg;

   localparam int unsigned DEFAULT_N          = 16;
   localparam int unsigned DEFAULT_DATA_WIDTH = 64;
   localparam int unsigned MAX_LOGN           = 16;
   localparam int unsigned MAX_LOGN_W         = 4;

   // Ceiling log2 for elaboration-time sizing.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((33'd1 << i) < 33'(value)) r = 32'(i + 1);
      end
      return r;
   endfunction

   // Reverses the low 'width' bits of idx; upper bits return zero.
   function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] idx,
                                                  input int unsigned         width);
      logic [MAX_LOGN-1:0] r;
      r = '0;
      for (int i = 0; i < int'(MAX_LOGN); i++) begin
         if (i < int'(width)) r[MAX_LOGN_W'(i)] = idx[MAX_LOGN_W'(int'(width) - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/sdf_reorder_bank.sv
// One N-word reorder bank: synchronous write port, combinational read port.
module sdf_reorder_bank #(
   parameter int unsigned data_width = 64,
   parameter int unsigned N          = 16,
   parameter int unsigned LOGN       = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [LOGN-1:0]       waddr,
   input  logic [data_width-1:0] wdata,
   input  logic [LOGN-1:0]       raddr,
   output logic [data_width-1:0] rdata
);

   logic [data_width-1:0] mem_q [N];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer: absorbs bit-reversed frames from the
// last SDF stage and replays them in natural order, one sample per cycle.
module sdf_bitrev_reorder
   import sdf_pkg::*;
#(
   parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
   parameter int unsigned N          = DEFAULT_N,
   parameter int unsigned LOGN       = clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [data_width-1:0] in_data,
   output logic                  out_valid,
   output logic [data_width-1:0] out_data,
   output logic                  out_last,
   output logic                  overflow
);

   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

   logic [1:0]            bank_full_q, bank_full_d;
   logic                  wsel_q, wsel_d;
   logic                  rsel_q, rsel_d;
   logic [LOGN-1:0]       wr_cnt_q, wr_cnt_d;
   logic [LOGN-1:0]       rd_cnt_q, rd_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  overflow_q, overflow_d;
   logic [data_width-1:0] out_data_q, out_data_d;

   logic                  wr_accept;
   logic                  rd_go;
   logic [LOGN-1:0]       waddr;
   logic [data_width-1:0] rdata [2];

   assign wr_accept = in_valid && !bank_full_q[wsel_q];
   assign rd_go     = bank_full_q[rsel_q];
   assign waddr     = LOGN'(bitrev(MAX_LOGN'(wr_cnt_q), LOGN));

   for (genvar b = 0; b < 2; b++) begin : g_bank
      sdf_reorder_bank #(
         .data_width(data_width),
         .N         (N),
         .LOGN      (LOGN)
      ) u_bank (
         .clk  (clk),
         .we   (wr_accept && (wsel_q == 1'(b))),
         .waddr(waddr),
         .wdata(in_data),
         .raddr(rd_cnt_q),
         .rdata(rdata[b])
      );
   end

   // Writer fills one bank while the reader drains the other; a fill and a
   // drain completing on the same edge always touch different bank_full bits.
   always_comb begin
      bank_full_d = bank_full_q;
      wsel_d      = wsel_q;
      rsel_d      = rsel_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      overflow_d  = overflow_q;

      if (in_valid && bank_full_q[wsel_q]) overflow_d = 1'b1;

      if (wr_accept) begin
         wr_cnt_d = wr_cnt_q + LOGN'(1);
         if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d            = '0;
            bank_full_d[wsel_q] = 1'b1;
            wsel_d              = !wsel_q;
         end
      end

      if (rd_go) begin
         out_data_d  = rdata[rsel_q];
         out_valid_d = 1'b1;
         out_last_d  = (rd_cnt_q == LAST_IDX);
         rd_cnt_d    = rd_cnt_q + LOGN'(1);
         if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d            = '0;
            bank_full_d[rsel_q] = 1'b0;
            rsel_d              = !rsel_q;
         end
      end
   end

   // rst_n is an active-high synchronous reset despite its name.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         bank_full_q <= '0;
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         bank_full_q <= bank_full_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed bench for sdf_bitrev_reorder (N=16) plus N=2 and N=64 builds.
module tb_sdf_bitrev_reorder;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;

   logic        out_valid, out_last, overflow;
   logic [63:0] out_data;
   logic        d2_valid, d2_last, d2_ovf;
   logic [63:0] d2_data;
   logic        d64_valid, d64_last, d64_ovf;
   logic [63:0] d64_data;

   int checks = 0;
   int errors = 0;

   // Natural index n of an N=16 frame holds arrival sample rev16[n].
   int unsigned rev16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   exp_t        expq[$];
   logic [63:0] cur [16];
   int          wcnt    = 0;
   bit          stalled = 1'b0;
   logic        ovf_exp = 1'b0;

   always #5 clk = ~clk;

   sdf_bitrev_reorder #(.data_width(64), .N(16), .LOGN(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .overflow(overflow)
   );

   sdf_bitrev_reorder #(.data_width(64), .N(2), .LOGN(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(d2_valid), .out_data(d2_data), .out_last(d2_last), .overflow(d2_ovf)
   );

   sdf_bitrev_reorder #(.data_width(64), .N(64), .LOGN(6)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(d64_valid), .out_data(d64_data), .out_last(d64_last), .overflow(d64_ovf)
   );

   function automatic int unsigned rev_bits(input int unsigned x, input int unsigned w);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < w; i++) r = (r << 1) | ((x >> i) & 1);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic iv_during);
      rst_n    = 1'b1;
      in_valid = iv_during;
      in_data  = 64'hbad;
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      expq.delete();
      wcnt    = 0;
      ovf_exp = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
   endtask

   // One clock: drive inputs, check the main DUT after the edge, update the model.
   task automatic cycle(input logic iv, input logic [63:0] d, input bit drop);
      exp_t e;
      in_valid = iv;
      in_data  = d;
      if (iv && drop) ovf_exp = 1'b1;
      @(posedge clk);
      #1;
      if (stalled) begin
         chk("stall_valid", 64'(out_valid), 64'd0);
      end else if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_data", out_data, e.data);
         chk("out_last", 64'(out_last), 64'(e.last));
      end else begin
         chk("idle_valid", 64'(out_valid), 64'd0);
         chk("idle_last", 64'(out_last), 64'd0);
      end
      chk("overflow", 64'(overflow), 64'(ovf_exp));
      if (iv && !drop) begin
         cur[wcnt] = d;
         wcnt++;
         if (wcnt == 16) begin
            for (int n = 0; n < 16; n++) begin
               e.data = cur[rev16[n]];
               e.last = (n == 15);
               expq.push_back(e);
            end
            wcnt = 0;
         end
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      do_reset(1'b0);

      // Ramp frame: outputs 0,8,4,12,... starting the edge after sample 15.
      for (int k = 0; k < 16; k++) cycle(1'b1, 64'(k), 1'b0);
      repeat (17) cycle(1'b0, 64'd0, 1'b0);

      // Four back-to-back frames, no bubbles.
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < 16; k++) cycle(1'b1, 64'(100 * f + k), 1'b0);
      repeat (17) cycle(1'b0, 64'd0, 1'b0);

      // Gapped input pauses only the write counter.
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 64'(500 + k), 1'b0);
         cycle(1'b0, 64'hdead, 1'b0);
      end
      repeat (17) cycle(1'b0, 64'd0, 1'b0);

      // Reset after 7 samples (with in_valid high during reset) discards them.
      for (int k = 0; k < 7; k++) cycle(1'b1, 64'(900 + k), 1'b0);
      do_reset(1'b1);
      for (int k = 0; k < 16; k++) cycle(1'b1, 64'(700 + k), 1'b0);
      repeat (17) cycle(1'b0, 64'd0, 1'b0);

      // Reader held idle: two frames fill both banks, a third-frame sample overflows.
      do_reset(1'b0);
      force dut.rd_go = 1'b0;
      stalled = 1'b1;
      for (int k = 0; k < 32; k++) cycle(1'b1, 64'(200 + k), 1'b0);
      cycle(1'b1, 64'd999, 1'b1);
      repeat (3) cycle(1'b0, 64'd0, 1'b0);
      release dut.rd_go;
      stalled = 1'b0;
      repeat (34) cycle(1'b0, 64'd0, 1'b0);
      do_reset(1'b0);

      // N=2 build: ramp 0,1 comes out as 0,1.
      cycle(1'b1, 64'd0, 1'b0);
      cycle(1'b1, 64'd1, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("n2_valid0", 64'(d2_valid), 64'd1);
      chk("n2_data0", d2_data, 64'd0);
      chk("n2_last0", 64'(d2_last), 64'd0);
      @(posedge clk); #1;
      chk("n2_valid1", 64'(d2_valid), 64'd1);
      chk("n2_data1", d2_data, 64'd1);
      chk("n2_last1", 64'(d2_last), 64'd1);
      @(posedge clk); #1;
      chk("n2_idle", 64'(d2_valid), 64'd0);
      chk("n2_ovf", 64'(d2_ovf), 64'd0);

      // N=64 build: ramp 0..63 drains as bitrev6(n).
      do_reset(1'b0);
      for (int k = 0; k < 64; k++) cycle(1'b1, 64'(k), 1'b0);
      for (int n = 0; n < 64; n++) begin
         cycle(1'b0, 64'd0, 1'b0);
         chk("n64_valid", 64'(d64_valid), 64'd1);
         chk("n64_data", d64_data, 64'(rev_bits(n, 6)));
         chk("n64_last", 64'(d64_last), 64'(n == 63));
      end
      cycle(1'b0, 64'd0, 1'b0);
      chk("n64_idle", 64'(d64_valid), 64'd0);
      chk("n64_ovf", 64'(d64_ovf), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
